// File: rtl/decode_stage.sv
// Buffered ARM decode stage: a small {instr, pc} FIFO feeding a registered,
// fully decoded output bundle with valid/ready handshake and pipeline flush.
module decode_stage #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = 32,
    parameter bit EN_MULTIPLY = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_instr,
    input  logic [ADDR_W-1:0]             in_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W-1:0]             out_pc,
    output logic [3:0]                    out_cond,
    output logic [2:0]                    out_class,
    output logic [3:0]                    out_opcode,
    output logic                          out_set_flags,
    output logic [3:0]                    out_rd,
    output logic [3:0]                    out_rn,
    output logic [3:0]                    out_rm,
    output logic [3:0]                    out_rs,
    output logic                          out_use_rs,
    output logic [1:0]                    out_shift,
    output logic [4:0]                    out_shift_amount,
    output logic [3:0]                    out_rotate_imm,
    output logic [7:0]                    out_imm8,
    output logic [11:0]                   out_offset12,
    output logic [4:0]                    out_pubwl,
    output logic                          out_link,
    output logic [23:0]                   out_imm24,
    output logic                          out_accumulate,
    output logic                          out_mem_read,
    output logic                          out_mem_write,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        CLS_DP_REG = 3'd0,
        CLS_DP_IMM = 3'd1,
        CLS_LS_IMM = 3'd2,
        CLS_LS_REG = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_MUL    = 3'd5,
        CLS_SWI    = 3'd6,
        CLS_UNDEF  = 3'd7
    } class_e;

    typedef struct packed {
        logic [3:0]  cond;
        class_e      cls;
        logic [3:0]  opcode;
        logic        set_flags;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic        use_rs;
        logic [1:0]  shift;
        logic [4:0]  shift_amount;
        logic [3:0]  rotate_imm;
        logic [7:0]  imm8;
        logic [11:0] offset12;
        logic [4:0]  pubwl;
        logic        link;
        logic [23:0] imm24;
        logic        accumulate;
        logic        mem_read;
        logic        mem_write;
    } bundle_t;

    // Fields not meaningful for the decoded class stay zero; UNDEF keeps only cond.
    function automatic bundle_t decode(input logic [31:0] w);
        bundle_t b;
        logic    undef;
        // NOTE: every field gets a default before any branch, so no latch is implied.
        b     = '0;
        undef = 1'b0;
        if (w[31:28] == 4'hF) begin
            undef = 1'b1;
        end else if (w[27:24] == 4'hF) begin
            b.cls = CLS_SWI;
        end else if (w[27:22] == 6'b0 && w[7:4] == 4'b1001) begin
            if (EN_MULTIPLY) begin
                b.cls        = CLS_MUL;
                b.rd         = w[19:16];
                b.rn         = w[15:12];
                b.rs         = w[11:8];
                b.rm         = w[3:0];
                b.accumulate = w[21];
                b.set_flags  = w[20];
            end else begin
                undef = 1'b1;
            end
        end else begin
            unique case (w[27:25])
                3'b000, 3'b001: begin
                    b.opcode    = w[24:21];
                    b.set_flags = w[20];
                    b.rn        = w[19:16];
                    b.rd        = w[15:12];
                    if (w[25]) begin
                        b.cls        = CLS_DP_IMM;
                        b.rotate_imm = w[11:8];
                        b.imm8       = w[7:0];
                    end else begin
                        b.cls    = CLS_DP_REG;
                        b.use_rs = w[4];
                        b.shift  = w[6:5];
                        b.rm     = w[3:0];
                        if (w[4]) b.rs = w[11:8];
                        else      b.shift_amount = w[11:7];
                        if (w[4] && w[7]) undef = 1'b1;
                    end
                    // Compare/test opcodes without S are not valid data-processing ops.
                    if (w[24:23] == 2'b10 && !w[20]) undef = 1'b1;
                end
                3'b010, 3'b011: begin
                    b.pubwl     = w[24:20];
                    b.rn        = w[19:16];
                    b.rd        = w[15:12];
                    b.mem_read  = w[20];
                    b.mem_write = !w[20];
                    if (w[25]) begin
                        b.cls          = CLS_LS_REG;
                        b.rm           = w[3:0];
                        b.shift_amount = w[11:7];
                        b.shift        = w[6:5];
                        if (w[4]) undef = 1'b1;
                    end else begin
                        b.cls      = CLS_LS_IMM;
                        b.offset12 = w[11:0];
                    end
                end
                3'b101: begin
                    b.cls   = CLS_BRANCH;
                    b.link  = w[24];
                    b.imm24 = w[23:0];
                end
                default: undef = 1'b1;
            endcase
        end
        if (undef) begin
            b     = '0;
            b.cls = CLS_UNDEF;
        end
        b.cond = w[31:28];
        return b;
    endfunction

    logic [31:0]       fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop;
    bundle_t           out_q;
    logic [ADDR_W-1:0] out_pc_q;
    logic              out_valid_q;

    assign in_ready = (count < CNT_W'(FIFO_DEPTH)) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = (!out_valid_q || out_ready) && (count != '0);

    // NOTE: the storage array has no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= in_instr;
            fifo_pc[wr_ptr]    <= in_pc;
        end
    end

    // NOTE: state registers use non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_q       <= decode(fifo_instr[rd_ptr]);
            out_pc_q    <= fifo_pc[rd_ptr];
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign fifo_count       = count;
    assign out_valid        = out_valid_q;
    assign out_pc           = out_pc_q;
    assign out_cond         = out_q.cond;
    assign out_class        = out_q.cls;
    assign out_opcode       = out_q.opcode;
    assign out_set_flags    = out_q.set_flags;
    assign out_rd           = out_q.rd;
    assign out_rn           = out_q.rn;
    assign out_rm           = out_q.rm;
    assign out_rs           = out_q.rs;
    assign out_use_rs       = out_q.use_rs;
    assign out_shift        = out_q.shift;
    assign out_shift_amount = out_q.shift_amount;
    assign out_rotate_imm   = out_q.rotate_imm;
    assign out_imm8         = out_q.imm8;
    assign out_offset12     = out_q.offset12;
    assign out_pubwl        = out_q.pubwl;
    assign out_link         = out_q.link;
    assign out_imm24        = out_q.imm24;
    assign out_accumulate   = out_q.accumulate;
    assign out_mem_read     = out_q.mem_read;
    assign out_mem_write    = out_q.mem_write;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus records accepted words, a monitor
// compares every output transfer against a behavioural ARM decode model.
module tb_decode_stage;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [AW-1:0] in_pc;

    logic in_ready, out_valid, out_set_flags, out_use_rs, out_link, out_accumulate;
    logic out_mem_read, out_mem_write;
    logic [AW-1:0] out_pc;
    logic [3:0] out_cond, out_opcode, out_rd, out_rn, out_rm, out_rs, out_rotate_imm;
    logic [2:0] out_class, fifo_count;
    logic [1:0] out_shift;
    logic [4:0] out_shift_amount, out_pubwl;
    logic [7:0] out_imm8;
    logic [11:0] out_offset12;
    logic [23:0] out_imm24;

    // Second instance without multiply support, fed identically.
    logic n_in_ready, n_out_valid, n_set_flags, n_use_rs, n_link, n_accumulate;
    logic n_mem_read, n_mem_write;
    logic [AW-1:0] n_pc;
    logic [3:0] n_cond, n_opcode, n_rd, n_rn, n_rm, n_rs, n_rotate_imm;
    logic [2:0] n_class, n_fifo_count;
    logic [1:0] n_shift;
    logic [4:0] n_shift_amount, n_pubwl;
    logic [7:0] n_imm8;
    logic [11:0] n_offset12;
    logic [23:0] n_imm24;

    always #5 clk = ~clk;

    decode_stage #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .EN_MULTIPLY(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_cond(out_cond), .out_class(out_class), .out_opcode(out_opcode),
        .out_set_flags(out_set_flags), .out_rd(out_rd), .out_rn(out_rn), .out_rm(out_rm),
        .out_rs(out_rs), .out_use_rs(out_use_rs), .out_shift(out_shift),
        .out_shift_amount(out_shift_amount), .out_rotate_imm(out_rotate_imm),
        .out_imm8(out_imm8), .out_offset12(out_offset12), .out_pubwl(out_pubwl),
        .out_link(out_link), .out_imm24(out_imm24), .out_accumulate(out_accumulate),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .fifo_count(fifo_count)
    );

    decode_stage #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .EN_MULTIPLY(1'b0)) dut_nomul (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_pc(n_pc), .out_cond(n_cond), .out_class(n_class), .out_opcode(n_opcode),
        .out_set_flags(n_set_flags), .out_rd(n_rd), .out_rn(n_rn), .out_rm(n_rm),
        .out_rs(n_rs), .out_use_rs(n_use_rs), .out_shift(n_shift),
        .out_shift_amount(n_shift_amount), .out_rotate_imm(n_rotate_imm),
        .out_imm8(n_imm8), .out_offset12(n_offset12), .out_pubwl(n_pubwl),
        .out_link(n_link), .out_imm24(n_imm24), .out_accumulate(n_accumulate),
        .out_mem_read(n_mem_read), .out_mem_write(n_mem_write), .fifo_count(n_fifo_count)
    );

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [3:0]  cond;
        logic [2:0]  cls;
        logic [3:0]  opcode;
        logic        s;
        logic [3:0]  rd, rn, rm, rs;
        logic        use_rs;
        logic [1:0]  shift;
        logic [4:0]  amt;
        logic [3:0]  rot;
        logic [7:0]  imm8;
        logic [11:0] off12;
        logic [4:0]  pubwl;
        logic        link;
        logic [23:0] imm24;
        logic        acc, mr, mw;
    } exp_t;

    typedef struct {
        logic [31:0]   instr;
        logic [AW-1:0] pc;
    } item_t;

    item_t exp_q[$];
    int n_pass = 0;
    int n_total = 0;
    int n_xfer = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic exp_t dut_bundle();
        return {out_pc, out_cond, out_class, out_opcode, out_set_flags, out_rd, out_rn, out_rm,
                out_rs, out_use_rs, out_shift, out_shift_amount, out_rotate_imm, out_imm8,
                out_offset12, out_pubwl, out_link, out_imm24, out_accumulate, out_mem_read,
                out_mem_write};
    endfunction

    // Classify first from the instruction-set rules, then fill the class's fields.
    function automatic exp_t model(input logic [31:0] w, input logic [AW-1:0] pc, input bit en_mul);
        exp_t e;
        int   cls;
        e = '0;
        e.pc   = pc;
        e.cond = w[31:28];
        if (w[31:28] == 4'hF)                            cls = 7;
        else if (w[27:24] == 4'hF)                       cls = 6;
        else if (w[27:22] == 6'd0 && w[7:4] == 4'b1001)  cls = en_mul ? 5 : 7;
        else if (w[27:25] == 3'd0)                       cls = (w[4] && w[7]) ? 7 : 0;
        else if (w[27:25] == 3'd1)                       cls = 1;
        else if (w[27:25] == 3'd2)                       cls = 2;
        else if (w[27:25] == 3'd3)                       cls = w[4] ? 7 : 3;
        else if (w[27:25] == 3'd5)                       cls = 4;
        else                                             cls = 7;
        if ((cls == 0 || cls == 1) && w[24:23] == 2'b10 && !w[20]) cls = 7;
        e.cls = 3'(cls);
        case (cls)
            0, 1: begin
                e.opcode = w[24:21]; e.s = w[20]; e.rn = w[19:16]; e.rd = w[15:12];
                if (cls == 1) begin
                    e.rot = w[11:8]; e.imm8 = w[7:0];
                end else begin
                    e.use_rs = w[4]; e.shift = w[6:5]; e.rm = w[3:0];
                    if (w[4]) e.rs = w[11:8]; else e.amt = w[11:7];
                end
            end
            2, 3: begin
                e.pubwl = w[24:20]; e.rn = w[19:16]; e.rd = w[15:12];
                e.mr = w[20]; e.mw = !w[20];
                if (cls == 2) e.off12 = w[11:0];
                else begin e.rm = w[3:0]; e.amt = w[11:7]; e.shift = w[6:5]; end
            end
            4: begin e.link = w[24]; e.imm24 = w[23:0]; end
            5: begin
                e.rd = w[19:16]; e.rn = w[15:12]; e.rs = w[11:8]; e.rm = w[3:0];
                e.acc = w[21]; e.s = w[20];
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: begin w[27:22] = 6'd0; w[7:4] = 4'b1001; end
            1: w[27:25] = 3'b101;
            2: w[27:25] = 3'b010;
            3: w[27:25] = 3'b011;
            4: w[27:25] = 3'b000;
            5: w[27:25] = 3'b001;
            default: ;
        endcase
        if ($urandom_range(0, 9) != 0) w[31:28] = 4'hE;
        return w;
    endfunction

    // Monitor: retire transfers against the scoreboard, then record new acceptances.
    always @(negedge clk) begin
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    item_t it;
                    it = exp_q.pop_front();
                    check("bundle", dut_bundle(), model(it.instr, it.pc, 1'b1));
                    check("nomul_class", {n_out_valid, n_class},
                          {1'b1, model(it.instr, it.pc, 1'b0).cls});
                end
            end
            if (in_valid && in_ready) exp_q.push_back('{instr: in_instr, pc: in_pc});
        end
    end

    // Offer one word; acc reports whether it was taken within max_wait edges.
    task automatic send(input logic [31:0] w, input logic [AW-1:0] pc, input int max_wait,
                        output bit acc);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        acc      = 1'b0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 0);
    endtask

    // Push into an idle stage and confirm the one-cycle latency.
    task automatic send_idle(input logic [31:0] w, input logic [AW-1:0] pc);
        bit acc;
        send(w, pc, 4, acc);
        check("accept", acc, 1);
        check("latency_n", out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_n1", out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   acc;
        int   n_acc;
        int   x0;
        exp_t held;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_bundle", dut_bundle(), 0);
        check("reset_state", {out_valid, fifo_count, in_ready}, {1'b0, 3'd0, 1'b1});
        reset = 1'b0;

        send_idle(32'hE2821005, 32'h100);
        check("add_fields", {out_class, out_opcode, out_rd, out_rn, out_imm8, out_rotate_imm,
                             out_set_flags, out_mem_read, out_mem_write},
              {3'd1, 4'b0100, 4'd1, 4'd2, 8'h05, 4'd0, 1'b0, 1'b0, 1'b0});
        wait_drain();

        send_idle(32'hE1A00211, 32'h104);
        check("mov_fields", {out_class, out_use_rs, out_rs, out_rm, out_shift, out_shift_amount},
              {3'd0, 1'b1, 4'd2, 4'd1, 2'b00, 5'd0});
        wait_drain();

        send(32'hE5910004, 32'h108, 4, acc);
        send(32'hEB000010, 32'h10C, 4, acc);
        check("ldr_fields", {out_valid, out_class, out_pubwl, out_offset12, out_mem_read, out_mem_write},
              {1'b1, 3'd2, 5'b11001, 12'd4, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        check("bl_fields", {out_valid, out_class, out_link, out_imm24, out_pc},
              {1'b1, 3'd4, 1'b1, 24'h000010, 32'h10C});
        wait_drain();

        send_idle(32'hE0232190, 32'h110);
        check("mla_fields", {out_class, out_rd, out_rn, out_rs, out_rm, out_accumulate, n_class},
              {3'd5, 4'd3, 4'd2, 4'd1, 4'd0, 1'b1, 3'd7});
        wait_drain();

        // Stall: only output register plus FIFO capacity may be accepted.
        out_ready = 1'b0;
        n_acc = 0;
        x0 = n_xfer;
        for (int i = 0; i < 6; i++) begin
            send(rand_instr(), 32'h200 + 32'(4 * i), 4, acc);
            if (acc) n_acc++;
            if (i == 1) held = dut_bundle();
        end
        check("stall_accepted", 32'(n_acc), 5);
        check("stall_full", {in_ready, fifo_count, out_valid}, {1'b0, 3'd4, 1'b1});
        check("stall_stable", dut_bundle(), held);
        out_ready = 1'b1;
        wait_drain();
        check("stall_drained", 32'(n_xfer - x0), 5);

        // Flush with three buffered words and a valid output.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(rand_instr(), 32'h300 + 32'(4 * i), 4, acc);
        check("pre_flush", {fifo_count, out_valid}, {3'd3, 1'b1});
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'hE2821005; in_pc = 32'h3F0;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("post_flush", {fifo_count, out_valid}, {3'd0, 1'b0});
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_nothing_out", {out_valid, fifo_count}, 0);

        // Reset in the middle of a stream.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_instr(), 32'h400 + 32'(4 * i), 4, acc);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_bundle", dut_bundle(), 0);
        check("midreset_state", {out_valid, fifo_count}, 0);
        reset = 1'b0;
        out_ready = 1'b1;

        // Random traffic with random back-pressure and occasional flush.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
